// File: rtl/program_mode_sequencer_pkg.sv
// Shared definitions for the alarm-clock program-mode sequencer:
// FSM state encoding, editable field indices and the auto-repeat period helper.
package program_mode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EDIT  = 2'd1,
    ST_SAVE  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_CLK_HOURS     = 2'd0;
  localparam logic [1:0] FIELD_CLK_MINUTES   = 2'd1;
  localparam logic [1:0] FIELD_ALARM_HOURS   = 2'd2;
  localparam logic [1:0] FIELD_ALARM_MINUTES = 2'd3;

  // Auto-repeat strobe period: a tenth of a second, never shorter than one cycle.
  function automatic int repeat_period(input int ticks_per_sec);
    return (ticks_per_sec / 10 < 1) ? 1 : ticks_per_sec / 10;
  endfunction

endpackage

// File: rtl/program_mode_sequencer_rise_detect.sv
// One-cycle rising-edge detector. The pulse is combinational on the current
// sample so the consuming register can react in the same clock edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev;

  // Remember the previous sample of the level input.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/program_mode_sequencer.sv
// Program (setting) mode sequencer for the alarm clock.
// Enters EDIT on a trigger edge, walks field_sel on next_btn edges, forwards
// inc_btn edges as inc_pulse, and closes the session with save_pulse (after the
// last field) or abort_pulse (error or inactivity timeout).
// Optional feature macro: PROGRAM_AUTOREPEAT_EN enables inc_btn auto-repeat.
//
// Handshake note: there is no valid/ready flow here. Every strobe output
// (inc_pulse, save_pulse, abort_pulse) is a registered one-cycle pulse that the
// datapath must consume in the cycle it is high; nothing is held or retried.
module program_mode_sequencer
  import program_mode_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int TIMEOUT_S     = 5,
  parameter int NUM_FIELDS    = 4
) (
  input  logic       clk_100Hz,
  input  logic       rst,
  input  logic       trigger,
  input  logic       next_btn,
  input  logic       inc_btn,
  input  logic       error_detection,
  output logic [1:0] field_sel,
  output logic       inc_pulse,
  output logic       save_pulse,
  output logic       abort_pulse,
  output logic [2:0] seconds_left,
  output logic       active_program_mode,
  output state_t     state_dbg
);

  localparam int              PW         = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [2:0]      SEC_RELOAD = 3'(TIMEOUT_S);
  localparam logic [1:0]      FIELD_LAST = 2'(NUM_FIELDS - 1);

  state_t          state, state_d;
  logic [PW-1:0]   presc, presc_d;
  logic [1:0]      field_d;
  logic [2:0]      sec_d;
  logic            inc_d, save_d, abort_d, active_d;
  logic            trig_rise, next_rise, inc_rise;
  logic            tick, rpt_fire;

  rise_detect u_trig_edge (.clk(clk_100Hz), .rst(rst), .level(trigger),  .rise(trig_rise));
  rise_detect u_next_edge (.clk(clk_100Hz), .rst(rst), .level(next_btn), .rise(next_rise));
  rise_detect u_inc_edge  (.clk(clk_100Hz), .rst(rst), .level(inc_btn),  .rise(inc_rise));

  // One-second tick: prescaler wraps only while editing.
  assign tick      = (presc == PRESC_LAST);
  assign state_dbg = state;

`ifdef PROGRAM_AUTOREPEAT_EN
  localparam int            HW         = $clog2(TICKS_PER_SEC);
  localparam int            RPT        = repeat_period(TICKS_PER_SEC);
  localparam logic [HW-1:0] HOLD_FIRE  = HW'(TICKS_PER_SEC - 1);
  localparam logic [HW-1:0] HOLD_REARM = HW'(TICKS_PER_SEC - RPT);

  logic [HW-1:0] hold_cnt, hold_d;

  // Count consecutive high samples since the inc edge; zero means no hold armed.
  always_comb begin
    rpt_fire = (state == ST_EDIT) && inc_btn && !inc_rise && (hold_cnt == HOLD_FIRE);
    hold_d   = hold_cnt;
    if (state != ST_EDIT || !inc_btn) hold_d = '0;
    else if (inc_rise)                hold_d = HW'(1);
    else if (hold_cnt == '0)          hold_d = '0;
    else if (rpt_fire)                hold_d = HOLD_REARM;
    else                              hold_d = hold_cnt + HW'(1);
  end

  // Hold counter register.
  always_ff @(posedge clk_100Hz) begin
    if (rst) hold_cnt <= '0;
    else     hold_cnt <= hold_d;
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Next-state and next-output logic; one event acts per cycle, in priority order.
  always_comb begin
    state_d  = state;
    field_d  = field_sel;
    sec_d    = seconds_left;
    presc_d  = presc;
    inc_d    = 1'b0;
    save_d   = 1'b0;
    abort_d  = 1'b0;
    active_d = active_program_mode;
    case (state)
      ST_IDLE: begin
        if (trig_rise) begin
          state_d  = ST_EDIT;
          field_d  = FIELD_CLK_HOURS;
          sec_d    = SEC_RELOAD;
          presc_d  = '0;
          active_d = 1'b1;
        end
      end
      ST_EDIT: begin
        presc_d = tick ? '0 : presc + PW'(1);
        if (error_detection || (tick && seconds_left == 3'd1)) begin
          state_d  = ST_ABORT;
          abort_d  = 1'b1;
          active_d = 1'b0;
          sec_d    = 3'd0;
        end else if (next_rise && field_sel == FIELD_LAST) begin
          state_d  = ST_SAVE;
          save_d   = 1'b1;
          active_d = 1'b0;
          sec_d    = 3'd0;
        end else if (next_rise) begin
          field_d = field_sel + 2'd1;
          sec_d   = SEC_RELOAD;
          presc_d = '0;
        end else if (inc_rise || rpt_fire) begin
          inc_d   = 1'b1;
          sec_d   = SEC_RELOAD;
          presc_d = '0;
        end else if (tick) begin
          sec_d = seconds_left - 3'd1;
        end
      end
      ST_SAVE, ST_ABORT: begin
        // The strobe was raised on entry; this cycle returns to IDLE.
        state_d  = ST_IDLE;
        field_d  = FIELD_CLK_HOURS;
        sec_d    = 3'd0;
        presc_d  = '0;
        active_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_100Hz) begin
    if (rst) begin
      state               <= ST_IDLE;
      presc               <= '0;
      field_sel           <= FIELD_CLK_HOURS;
      seconds_left        <= 3'd0;
      inc_pulse           <= 1'b0;
      save_pulse          <= 1'b0;
      abort_pulse         <= 1'b0;
      active_program_mode <= 1'b0;
    end else begin
      state               <= state_d;
      presc               <= presc_d;
      field_sel           <= field_d;
      seconds_left        <= sec_d;
      inc_pulse           <= inc_d;
      save_pulse          <= save_d;
      abort_pulse         <= abort_d;
      active_program_mode <= active_d;
    end
  end

endmodule
